// File: rtl/impl_window_checker.sv
// impl_window_checker: multi-channel ant |-> ##[MIN_DLY:MAX_DLY] cons monitor
// with pass/fail pulses, saturating counters, sticky flags, first-fail record.
module impl_window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 0,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 32,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [NCH-1:0]       ant,
    input  logic [NCH-1:0]       cons,
    output logic [NCH-1:0]       pass_pulse,
    output logic [NCH-1:0]       fail_pulse,
    output logic [NCH-1:0]       fail_sticky,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic                 first_fail_valid,
    output logic [CH_W-1:0]      first_fail_ch,
    output logic [TS_W-1:0]      first_fail_ts
);

    localparam int D     = MAX_DLY + 1;
    localparam int PC_W  = $clog2(D + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [D-1:0]     WIN     = {D{1'b1}} << MIN_DLY;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (MIN_DLY > MAX_DLY || MAX_DLY > 15 || MIN_DLY < 0 || NCH < 1) begin : g_bad_param
        $error("impl_window_checker: illegal MIN_DLY/MAX_DLY/NCH");
    end

    // pend_q[c][k]: an attempt on channel c that had age k at the previous edge
    logic [NCH-1:0][D-1:0]     pend_q, pend_d, age, hit;
    logic [NCH-1:0][PC_W-1:0]  npass;
    logic [NCH-1:0][SUM_W-1:0] psum;
    logic [NCH-1:0][CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
    logic [NCH-1:0]            fail, pass_any;
    logic [NCH-1:0]            pp_q, fp_q, sticky_q;
    logic                      ffv_q, ff_hit;
    logic [CH_W-1:0]           ffch_q, ff_ch;
    logic [TS_W-1:0]           ts_q, ffts_q;

    // Age every attempt by one, resolve in-window passes and expiring fails
    always_comb begin
        age      = '0;
        hit      = '0;
        fail     = '0;
        pend_d   = '0;
        npass    = '0;
        pass_any = '0;
        psum     = '0;
        pcnt_d   = pcnt_q;
        fcnt_d   = fcnt_q;
        for (int c = 0; c < NCH; c++) begin
            age[c]  = (pend_q[c] << 1) | D'(ant[c]);
            hit[c]  = en ? (age[c] & WIN & {D{cons[c]}}) : '0;
            fail[c] = en & age[c][MAX_DLY] & ~cons[c];
            pend_d[c] = en ? (age[c] & ~hit[c]) : '0;
            pend_d[c][MAX_DLY] = 1'b0;
            for (int k = 0; k < D; k++) begin
                npass[c] = npass[c] + PC_W'(hit[c][k]);
            end
            pass_any[c] = |hit[c];
            psum[c] = SUM_W'(pcnt_q[c]) + SUM_W'(npass[c]);
            pcnt_d[c] = (psum[c] > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                    : psum[c][CNT_W-1:0];
            if (fail[c] && fcnt_q[c] != CNT_MAX) begin
                fcnt_d[c] = fcnt_q[c] + 1'b1;
            end
        end
    end

    // Lowest-index failing channel at this edge
    always_comb begin
        ff_hit = 1'b0;
        ff_ch  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (fail[c]) begin
                ff_hit = 1'b1;
                ff_ch  = CH_W'(c);
            end
        end
    end

    // All state: async reset, synchronous clear, otherwise register the events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= '0;
            pp_q     <= '0;
            fp_q     <= '0;
            sticky_q <= '0;
            pcnt_q   <= '0;
            fcnt_q   <= '0;
            ts_q     <= '0;
            ffv_q    <= 1'b0;
            ffch_q   <= '0;
            ffts_q   <= '0;
        end else if (clr) begin
            pend_q   <= '0;
            pp_q     <= '0;
            fp_q     <= '0;
            sticky_q <= '0;
            pcnt_q   <= '0;
            fcnt_q   <= '0;
            ts_q     <= '0;
            ffv_q    <= 1'b0;
            ffch_q   <= '0;
            ffts_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            pp_q     <= pass_any;
            fp_q     <= fail;
            sticky_q <= sticky_q | fail;
            pcnt_q   <= pcnt_d;
            fcnt_q   <= fcnt_d;
            ts_q     <= ts_q + 1'b1;
            if (!ffv_q && ff_hit) begin
                ffv_q  <= 1'b1;
                ffch_q <= ff_ch;
                ffts_q <= ts_q;
            end
        end
    end

    assign pass_pulse       = pp_q;
    assign fail_pulse       = fp_q;
    assign fail_sticky      = sticky_q;
    assign pass_cnt         = pcnt_q;
    assign fail_cnt         = fcnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_ch    = ffch_q;
    assign first_fail_ts    = ffts_q;

endmodule

// File: tb/tb_impl_window_checker.sv
// tb_impl_window_checker: directed and random checks of impl_window_checker
// against an attempt-list reference model.
module tb_impl_window_checker;

    localparam int NCH  = 4;
    localparam int MIN  = 1;
    localparam int MAX  = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic [NCH-1:0]    ant = '0;
    logic [NCH-1:0]    cons = '0;
    logic [NCH-1:0]    pass_pulse, fail_pulse, fail_sticky;
    logic [NCH*CW-1:0] pass_cnt, fail_cnt;
    logic              first_fail_valid;
    logic [1:0]        first_fail_ch;
    logic [31:0]       first_fail_ts;

    always #5 clk = ~clk;

    impl_window_checker #(
        .NCH(NCH), .MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(CW), .TS_W(32)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .ant(ant), .cons(cons),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .fail_sticky(fail_sticky),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid),
        .first_fail_ch(first_fail_ch),
        .first_fail_ts(first_fail_ts)
    );

    int n_chk = 0;
    int n_pass = 0;

    // reference model: list of attempt birth times per channel
    int       q[NCH][$];
    int       m_ts;
    bit [3:0] m_pp, m_fp, m_st;
    int       m_pc[NCH];
    int       m_fc[NCH];
    bit       m_ffv;
    int       m_ffch, m_ffts;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, obs, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            m_pc[c] = 0;
            m_fc[c] = 0;
        end
        m_ts = 0; m_pp = 0; m_fp = 0; m_st = 0;
        m_ffv = 0; m_ffch = 0; m_ffts = 0;
    endtask

    task automatic model_step(input bit [3:0] a, input bit [3:0] c,
                              input bit e, input bit cl);
        int now;
        if (cl) begin
            model_reset();
            return;
        end
        now = m_ts;
        m_ts++;
        m_pp = 0;
        m_fp = 0;
        if (!e) begin
            for (int ch = 0; ch < NCH; ch++) q[ch].delete();
            return;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            int keep[$];
            int np;
            bit fl;
            np = 0;
            fl = 0;
            if (a[ch]) q[ch].push_back(now);
            for (int i = 0; i < q[ch].size(); i++) begin
                int agev;
                agev = now - q[ch][i];
                if (agev >= MIN && c[ch]) np++;
                else if (agev == MAX) fl = 1;
                else keep.push_back(q[ch][i]);
            end
            q[ch] = keep;
            if (np > 0) begin
                m_pp[ch] = 1;
                m_pc[ch] = sat(m_pc[ch] + np);
            end
            if (fl) begin
                m_fp[ch] = 1;
                m_st[ch] = 1;
                m_fc[ch] = sat(m_fc[ch] + 1);
                if (!m_ffv) begin
                    m_ffv = 1;
                    m_ffch = ch;
                    m_ffts = now;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("pass_pulse", 64'(pass_pulse), 64'(m_pp));
        chk("fail_pulse", 64'(fail_pulse), 64'(m_fp));
        chk("fail_sticky", 64'(fail_sticky), 64'(m_st));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("pass_cnt%0d", c), 64'(pass_cnt[c*CW +: CW]),
                64'(m_pc[c]));
            chk($sformatf("fail_cnt%0d", c), 64'(fail_cnt[c*CW +: CW]),
                64'(m_fc[c]));
        end
        chk("ff_valid", 64'(first_fail_valid), 64'(m_ffv));
        chk("ff_ch", 64'(first_fail_ch), 64'(m_ffch));
        chk("ff_ts", 64'(first_fail_ts), 64'(m_ffts));
    endtask

    // called at a negedge; returns at the following negedge
    task automatic step(input bit [3:0] a, input bit [3:0] c,
                        input bit e = 1'b1, input bit cl = 1'b0);
        ant = a; cons = c; en = e; clr = cl;
        model_step(a, c, e, cl);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle_to(input int edge_n);
        while (m_ts < edge_n) step(4'b0, 4'b0);
    endtask

    task automatic do_reset();
        ant = '0; cons = '0; en = 1'b0; clr = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit [3:0] ra, rc;

        // block A: single pass, then two overlapping attempts passing together
        do_reset();
        idle_to(10);
        step(4'b0001, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0001);
        chk("t1_pp_on", 64'(pass_pulse[0]), 64'd1);
        step(4'b0000, 4'b0000);
        chk("t1_pp_off", 64'(pass_pulse[0]), 64'd0);
        idle_to(16);
        chk("t1_pcnt", 64'(pass_cnt[3:0]), 64'd1);
        chk("t1_fcnt", 64'(fail_cnt[3:0]), 64'd0);
        chk("t1_sticky", 64'(fail_sticky), 64'd0);
        idle_to(20);
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        step(4'b0000, 4'b0001);
        chk("t3_pp", 64'(pass_pulse[0]), 64'd1);
        chk("t3_pcnt", 64'(pass_cnt[3:0]), 64'd3);
        step(4'b0000, 4'b0000);
        chk("t3_pp_off", 64'(pass_pulse[0]), 64'd0);

        // block B: cons at age 0 is too early, attempt fails at MAX
        do_reset();
        idle_to(10);
        step(4'b0010, 4'b0010);
        idle_to(13);
        step(4'b0000, 4'b0000);
        chk("t2_fp", 64'(fail_pulse[1]), 64'd1);
        chk("t2_sticky", 64'(fail_sticky[1]), 64'd1);
        chk("t2_ffv", 64'(first_fail_valid), 64'd1);
        chk("t2_ffch", 64'(first_fail_ch), 64'd1);
        chk("t2_ffts", 64'(first_fail_ts), 64'd13);

        // block C: simultaneous fails, later fail, enable flush
        do_reset();
        idle_to(20);
        step(4'b1100, 4'b0000);
        idle_to(23);
        step(4'b0000, 4'b0000);
        chk("t4_ffch", 64'(first_fail_ch), 64'd2);
        chk("t4_ffts", 64'(first_fail_ts), 64'd23);
        chk("t4_fc2", 64'(fail_cnt[11:8]), 64'd1);
        chk("t4_fc3", 64'(fail_cnt[15:12]), 64'd1);
        idle_to(25);
        step(4'b0001, 4'b0000);
        idle_to(28);
        step(4'b0000, 4'b0000);
        chk("t4_fp0", 64'(fail_pulse[0]), 64'd1);
        chk("t4_ffch_hold", 64'(first_fail_ch), 64'd2);
        chk("t4_ffts_hold", 64'(first_fail_ts), 64'd23);
        idle_to(30);
        step(4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001);
        idle_to(36);
        chk("t6_pcnt0", 64'(pass_cnt[3:0]), 64'd0);
        chk("t6_fcnt0", 64'(fail_cnt[3:0]), 64'd1);

        // block D: saturation, then synchronous clear
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 4'b0000);
            step(4'b0000, 4'b0001);
            step(4'b0000, 4'b0000);
        end
        chk("t5_sat", 64'(pass_cnt[3:0]), 64'd15);
        step(4'b1000, 4'b0000);
        repeat (3) step(4'b0000, 4'b0000);
        chk("t5_sat_hold", 64'(pass_cnt[3:0]), 64'd15);
        chk("t5_sticky3", 64'(fail_sticky[3]), 64'd1);
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        chk("t5_clr_pcnt", 64'(pass_cnt), 64'd0);
        chk("t5_clr_fcnt", 64'(fail_cnt), 64'd0);
        chk("t5_clr_sticky", 64'(fail_sticky), 64'd0);
        step(4'b1000, 4'b0000);
        repeat (3) step(4'b0000, 4'b0000);
        chk("t5_ts_restart", 64'(first_fail_ts), 64'd3);

        // block E: random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ra[c] = ($urandom_range(0, 99) < 30);
                rc[c] = ($urandom_range(0, 99) < 35);
            end
            step(ra, rc, ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 299) == 0));
        end

        // reset asserted between edges with attempts pending
        step(4'b1111, 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_pcnt", 64'(pass_cnt), 64'd0);
        chk("t6_rst_fcnt", 64'(fail_cnt), 64'd0);
        chk("t6_rst_sticky", 64'(fail_sticky), 64'd0);
        chk("t6_rst_ffv", 64'(first_fail_valid), 64'd0);
        model_reset();
        check_all();
        ant = '0; cons = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step(4'b0000, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
